// File: rtl/fdtd_ez_writeback.sv
// fdtd_ez_writeback: tags selected Ez words with RAM addresses, buffers them and drains them to Ez memory
// Ports:
//   CLK, RST_N                  clock, asynchronous active-low reset
//   start_i                     begin a sweep (IDLE only)
//   calc_Ez_en_i, calc_src_en_i Ez_n_i carries a total-field / source-load word
//   Ez_n_i                      selected Ez word
//   wr_en_o, wr_addr_o, wr_data_o, wr_ready_i  memory write port (valid/ready)
//   busy_o, step_done_o         sweep status
//   overflow_o, conflict_o      sticky error flags
module fdtd_ez_writeback #(
    parameter int FDTD_DATA_WIDTH = 80,
    parameter int CELL_NUM        = 256,
    parameter int ADDR_W          = 8,
    parameter int SRC_ADDR        = 128,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       start_i,
    input  logic                       calc_Ez_en_i,
    input  logic                       calc_src_en_i,
    input  logic [FDTD_DATA_WIDTH-1:0] Ez_n_i,
    output logic                       wr_en_o,
    output logic [ADDR_W-1:0]          wr_addr_o,
    output logic [FDTD_DATA_WIDTH-1:0] wr_data_o,
    input  logic                       wr_ready_i,
    output logic                       busy_o,
    output logic                       step_done_o,
    output logic                       overflow_o,
    output logic                       conflict_o
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                     r_state;
    logic [ADDR_W-1:0]          r_cnt;
    logic [ADDR_W-1:0]          r_addr_mem [FIFO_DEPTH];
    logic [FDTD_DATA_WIDTH-1:0] r_data_mem [FIFO_DEPTH];
    logic [PW-1:0]              r_wp, r_rp;
    logic [PW:0]                r_occ;
    logic                       r_ovf, r_conf;

    logic              w_ez, w_src, w_both, w_valid, w_full, w_pop, w_push, w_last;
    logic [ADDR_W-1:0] w_addr;

    assign w_ez    = calc_Ez_en_i & ~calc_src_en_i;
    assign w_src   = calc_src_en_i & ~calc_Ez_en_i;
    assign w_both  = calc_Ez_en_i & calc_src_en_i;
    assign w_valid = (r_state == RUN) & (w_ez | w_src);
    assign w_full  = r_occ == (PW+1)'(FIFO_DEPTH);
    assign w_pop   = wr_en_o & wr_ready_i;
    // a pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign w_push  = w_valid & (~w_full | w_pop);
    assign w_last  = r_cnt == ADDR_W'(CELL_NUM - 1);
    assign w_addr  = w_ez ? r_cnt : ADDR_W'(SRC_ADDR);

    assign wr_en_o     = r_occ != '0;
    assign wr_addr_o   = r_addr_mem[r_rp];
    assign wr_data_o   = r_data_mem[r_rp];
    assign busy_o      = r_state != IDLE;
    assign step_done_o = r_state == DONE;
    assign overflow_o  = r_ovf;
    assign conflict_o  = r_conf;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_occ   <= '0;
            r_ovf   <= 1'b0;
            r_conf  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_addr_mem[i] <= '0;
                r_data_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_addr_mem[r_wp] <= w_addr;
                r_data_mem[r_wp] <= Ez_n_i;
                r_wp             <= r_wp + PW'(1);
            end
            if (w_pop) r_rp <= r_rp + PW'(1);
            r_occ <= r_occ + (PW+1)'(w_push) - (PW+1)'(w_pop);
            if (w_valid && !w_push) r_ovf <= 1'b1;
            if (w_both) r_conf <= 1'b1;
            case (r_state)
                IDLE: if (start_i) begin
                    r_state <= RUN;
                    r_cnt   <= '0;
                end
                // dropped Ez words still count so addresses stay aligned with cells
                RUN: if (w_ez) begin
                    r_cnt <= w_last ? '0 : r_cnt + ADDR_W'(1);
                    if (w_last) r_state <= DRAIN;
                end
                DRAIN: if (r_occ == '0) r_state <= DONE;
                DONE:  r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fdtd_ez_writeback.sv
// tb_fdtd_ez_writeback: scoreboard bench for the Ez write-back stage
module tb_fdtd_ez_writeback;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start_i = 1'b0;
    logic        calc_Ez_en_i = 1'b0;
    logic        calc_src_en_i = 1'b0;
    logic [79:0] Ez_n_i = '0;
    logic        wr_en_o;
    logic [7:0]  wr_addr_o;
    logic [79:0] wr_data_o;
    logic        wr_ready_i = 1'b1;
    logic        busy_o, step_done_o, overflow_o, conflict_o;

    fdtd_ez_writeback dut (
        .CLK(CLK), .RST_N(RST_N), .start_i(start_i),
        .calc_Ez_en_i(calc_Ez_en_i), .calc_src_en_i(calc_src_en_i), .Ez_n_i(Ez_n_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_ready_i(wr_ready_i),
        .busy_o(busy_o), .step_done_o(step_done_o), .overflow_o(overflow_o), .conflict_o(conflict_o)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [87:0] q[$];
    logic [7:0]  m_cnt = '0;
    logic        m_run = 1'b0;
    logic        m_idle = 1'b1;
    logic        m_ovf = 1'b0;
    logic        m_conf = 1'b0;

    always @(negedge CLK) begin
        logic [87:0] e;
        if (step_done_o) done_cnt++;
        if (wr_en_o && wr_ready_i) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL write: got addr=%0d data=%0h, required no write", wr_addr_o, wr_data_o);
            end else begin
                e = q.pop_front();
                if ({wr_addr_o, wr_data_o} !== e) begin
                    n_err++;
                    $display("FAIL write: got addr=%0d data=%0h, required addr=%0d data=%0h",
                             wr_addr_o, wr_data_o, e[87:80], e[79:0]);
                end
            end
        end
    end

    task automatic send(input logic ez, input logic src, input logic [79:0] d);
        logic [7:0] a;
        calc_Ez_en_i = ez;
        calc_src_en_i = src;
        Ez_n_i = d;
        if (ez && src) m_conf = 1'b1;
        else if (m_run && (ez ^ src)) begin
            a = ez ? m_cnt : 8'd128;
            if (q.size() < 4 || (wr_ready_i && q.size() > 0)) q.push_back({a, d});
            else m_ovf = 1'b1;
            if (ez) begin
                if (m_cnt == 8'd255) m_run = 1'b0;
                m_cnt = m_cnt + 8'd1;
            end
        end
        @(posedge CLK); #1;
        calc_Ez_en_i = 1'b0;
        calc_src_en_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        if (m_idle) begin
            m_idle = 1'b0;
            m_run = 1'b1;
            m_cnt = '0;
        end
        @(posedge CLK); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n0 = done_cnt;
        int k = 0;
        while (done_cnt == n0 && k < 1000) begin
            @(posedge CLK); #1;
            k++;
        end
        repeat (3) @(posedge CLK);
        #1;
        n_vec++;
        if (done_cnt != n0 + 1) begin n_err++; $display("FAIL %s step_done pulses: got %0d, required 1", name, done_cnt - n0); end
        n_vec++;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL %s busy after sweep: got %b, required 0", name, busy_o); end
        n_vec++;
        if (q.size() != 0) begin n_err++; $display("FAIL %s pending writes: got %0d missing, required 0", name, q.size()); end
        n_vec++;
        if (overflow_o !== m_ovf) begin n_err++; $display("FAIL %s overflow_o: got %b, required %b", name, overflow_o, m_ovf); end
        n_vec++;
        if (conflict_o !== m_conf) begin n_err++; $display("FAIL %s conflict_o: got %b, required %b", name, conflict_o, m_conf); end
        m_idle = 1'b1;
        m_run = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        n_vec++;
        if ({wr_en_o, busy_o, step_done_o, overflow_o, conflict_o} !== 5'b0) begin
            n_err++;
            $display("FAIL reset flags: got %b, required 00000", {wr_en_o, busy_o, step_done_o, overflow_o, conflict_o});
        end
        n_vec++;
        if (wr_addr_o !== 8'd0 || wr_data_o !== 80'd0) begin
            n_err++;
            $display("FAIL reset wr bus: got addr=%0d data=%0h, required 0/0", wr_addr_o, wr_data_o);
        end
    endtask

    task automatic test_sweep();
        pulse_start();
        n_vec++;
        if (busy_o !== 1'b1) begin n_err++; $display("FAIL sweep busy: got %b, required 1", busy_o); end
        for (int i = 0; i < 256; i++) send(1'b1, 1'b0, 80'(i));
        wait_done("sweep");
    endtask

    task automatic test_source();
        pulse_start();
        for (int i = 0; i < 10; i++) send(1'b1, 1'b0, 80'(i));
        send(1'b0, 1'b1, 80'h1234);
        for (int i = 10; i < 256; i++) send(1'b1, 1'b0, 80'(i));
        wait_done("source");
    endtask

    task automatic test_ignored();
        send(1'b1, 1'b0, 80'd77);
        send(1'b0, 1'b1, 80'd5);
        n_vec++;
        if (wr_en_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL idle words: got wr_en=%b busy=%b, required 0/0", wr_en_o, busy_o);
        end
        pulse_start();
        for (int i = 0; i < 256; i++) begin
            if (i == 100) pulse_start();
            send(1'b1, 1'b0, 80'(i + 1000));
        end
        wait_done("ignored");
    endtask

    task automatic test_overflow();
        pulse_start();
        wr_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 80'(i));
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (wr_en_o !== 1'b1 || wr_addr_o !== 8'd0 || wr_data_o !== 80'd0) begin
                n_err++;
                $display("FAIL stall head: got en=%b addr=%0d data=%0h, required 1/0/0", wr_en_o, wr_addr_o, wr_data_o);
            end
            @(posedge CLK); #1;
        end
        n_vec++;
        if (overflow_o !== 1'b1) begin n_err++; $display("FAIL overflow flag: got %b, required 1", overflow_o); end
        wr_ready_i = 1'b1;
        for (int i = 5; i < 256; i++) send(1'b1, 1'b0, 80'(i));
        wait_done("overflow");
    endtask

    task automatic test_conflict();
        pulse_start();
        for (int i = 0; i < 20; i++) send(1'b1, 1'b0, 80'(i));
        send(1'b1, 1'b1, 80'hFF);
        n_vec++;
        if (conflict_o !== 1'b1) begin n_err++; $display("FAIL conflict flag: got %b, required 1", conflict_o); end
        for (int i = 20; i < 256; i++) send(1'b1, 1'b0, 80'(i));
        wait_done("conflict");
    endtask

    task automatic test_reset_mid();
        pulse_start();
        wr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 80'(i + 500));
        #3;
        RST_N = 1'b0;
        #1;
        n_vec++;
        if (wr_en_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL async reset: got wr_en=%b busy=%b, required 0/0", wr_en_o, busy_o);
        end
        n_vec++;
        if (overflow_o !== 1'b0 || conflict_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset sticky: got ovf=%b conf=%b, required 0/0", overflow_o, conflict_o);
        end
        q.delete();
        m_cnt = '0;
        m_run = 1'b0;
        m_idle = 1'b1;
        m_ovf = 1'b0;
        m_conf = 1'b0;
        wr_ready_i = 1'b1;
        @(posedge CLK); #2;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        pulse_start();
        for (int i = 0; i < 256; i++) send(1'b1, 1'b0, 80'(i + 2000));
        wait_done("after reset");
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_source();
        test_ignored();
        test_overflow();
        test_conflict();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
